// File: rtl/shift_left.sv
// Registered fixed-amount arithmetic left shift for the immediate path, with a
// valid qualifier and a signed-overflow flag; one cycle of latency.
module shift_left #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] signExtendedR2,
  output logic [WIDTH-1:0] shiftedOut,
  output logic             out_valid,
  output logic             overflow
);

  logic [WIDTH-1:0] w_shifted;
  logic [SHIFT:0]   w_top_bits;
  logic             w_overflow;

  logic [WIDTH-1:0] r_shifted;
  logic             r_overflow;
  logic             r_valid;

  assign w_shifted = signExtendedR2 << SHIFT;

  // The discarded bits plus the new sign bit must all agree for the signed
  // value to survive the shift; with SHIFT = 0 this is a single bit, so never.
  assign w_top_bits = signExtendedR2[WIDTH-1 -: SHIFT+1];
  assign w_overflow = (|w_top_bits) & ~(&w_top_bits);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shifted  <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_shifted  <= w_shifted;
        r_overflow <= w_overflow;
      end
    end
  end

  assign shiftedOut = r_shifted;
  assign overflow   = r_overflow;
  assign out_valid  = r_valid;

endmodule

// File: tb/tb_shift_left.sv
// Self-checking bench for shift_left: directed vectors plus random stimulus
// compared against an arithmetic reference model, for SHIFT = 1, 0 and 2.
module tb_shift_left;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] s1, s0, s2;
  logic        v1, v0, v2;
  logic        o1, o0, o2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_left #(.WIDTH(16), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .signExtendedR2(din),
    .shiftedOut(s1), .out_valid(v1), .overflow(o1));
  shift_left #(.WIDTH(16), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .signExtendedR2(din),
    .shiftedOut(s0), .out_valid(v0), .overflow(o0));
  shift_left #(.WIDTH(16), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .signExtendedR2(din),
    .shiftedOut(s2), .out_valid(v2), .overflow(o2));

  // Reference: multiply the signed operand by 2^s, keep the low 16 bits, and
  // flag overflow when the true product is outside the signed 16-bit range.
  function automatic logic [16:0] ref_shift(input int s, input logic [15:0] x);
    longint p;
    logic [15:0] lo;
    p  = longint'($signed(x)) * (longint'(1) << s);
    lo = p[15:0];
    return {(p > 32767 || p < -32768), lo};
  endfunction

  // Expected {out_valid, overflow, shiftedOut} per instance.
  logic [17:0] exp1, exp0, exp2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp1 <= '0; exp0 <= '0; exp2 <= '0;
    end else begin
      exp1[17] <= in_valid; exp0[17] <= in_valid; exp2[17] <= in_valid;
      if (in_valid) begin
        exp1[16:0] <= ref_shift(1, din);
        exp0[16:0] <= ref_shift(0, din);
        exp2[16:0] <= ref_shift(2, din);
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] d);
    in_valid = v;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 16'h4000);
    drive(1'b0, 16'h0000);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({v1, o1, s1} !== 18'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b ovf=%b out=%h, want v=0 ovf=0 out=0000", v1, o1, s1);
    end
    in_valid = 1'b1;
    din      = 16'h7FFF;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({v1, o1, s1} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%b ovf=%b out=%h, want all zero", v1, o1, s1);
    end
    rst = 1'b0;
    drive(1'b0, 16'h1111);
    n_checks++;
    if ({v1, o1, s1} !== 18'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%b ovf=%b out=%h, want all zero", v1, o1, s1);
    end
  endtask

  task automatic test_basic;
    logic [15:0] ins  [3] = '{16'h0005, 16'h0013, 16'h0007};
    logic [15:0] outs [3] = '{16'h000A, 16'h0026, 16'h000E};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i]);
      n_checks++;
      if ({v1, o1, s1} !== {1'b1, 1'b0, outs[i]}) begin
        n_fail++;
        $display("FAIL basic[%0d]: got v=%b ovf=%b out=%h, want v=1 ovf=0 out=%h", i, v1, o1, s1, outs[i]);
      end
    end
  endtask

  task automatic test_signed_cases;
    logic [15:0] ins  [5] = '{16'hFFFF, 16'hC000, 16'h4000, 16'h8000, 16'h7FFF};
    logic [15:0] outs [5] = '{16'hFFFE, 16'h8000, 16'h8000, 16'h0000, 16'hFFFE};
    logic        ovfs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ins[i]);
      n_checks++;
      if ({v1, o1, s1} !== {1'b1, ovfs[i], outs[i]}) begin
        n_fail++;
        $display("FAIL signed[%h]: got v=%b ovf=%b out=%h, want v=1 ovf=%b out=%h", ins[i], v1, o1, s1, ovfs[i], outs[i]);
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h1234);
      n_checks++;
      if ({v1, o1, s1} !== {1'b0, 1'b0, 16'h000A}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%b ovf=%b out=%h, want v=0 ovf=0 out=000a", i, v1, o1, s1);
      end
    end
  endtask

  task automatic test_param_sweep;
    drive(1'b1, 16'h0007);
    n_checks++;
    if ({v0, o0, s0, v2, o2, s2} !== {1'b1, 1'b0, 16'h0007, 1'b1, 1'b0, 16'h001C}) begin
      n_fail++;
      $display("FAIL sweep_0007: s0=%h o0=%b s2=%h o2=%b, want s0=0007 o0=0 s2=001c o2=0", s0, o0, s2, o2);
    end
    drive(1'b1, 16'h2000);
    n_checks++;
    if ({v0, o0, s0, v2, o2, s2} !== {1'b1, 1'b0, 16'h2000, 1'b1, 1'b1, 16'h8000}) begin
      n_fail++;
      $display("FAIL sweep_2000: s0=%h o0=%b s2=%h o2=%b, want s0=2000 o0=0 s2=8000 o2=1", s0, o0, s2, o2);
    end
    drive(1'b1, 16'h8000);
    n_checks++;
    if ({v0, o0, s0} !== {1'b1, 1'b0, 16'h8000}) begin
      n_fail++;
      $display("FAIL sweep_pass_8000: s0=%h o0=%b, want s0=8000 o0=0", s0, o0);
    end
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1;
    din      = 16'h0123;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({v1, o1, s1} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_mid_lost: got v=%b ovf=%b out=%h, want all zero", v1, o1, s1);
    end
    drive(1'b1, 16'h0040);
    n_checks++;
    if ({v1, o1, s1} !== {1'b1, 1'b0, 16'h0080}) begin
      n_fail++;
      $display("FAIL reset_mid_first: got v=%b ovf=%b out=%h, want v=1 ovf=0 out=0080", v1, o1, s1);
    end
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 16'($urandom));
      n_checks++;
      if ({v1, o1, s1, v0, o0, s0, v2, o2, s2} !== {exp1, exp0, exp2}) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: got %h/%h/%h, want %h/%h/%h", i,
                   {v1, o1, s1}, {v0, o0, s0}, {v2, o2, s2}, exp1, exp0, exp2);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [8];
    for (int i = 0; i < 8; i++) vals[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vals[i]);
      n_checks++;
      if ({v1, o1, s1} !== {1'b1, ref_shift(1, vals[i])}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got v=%b ovf=%b out=%h, want v=1 %h", i, v1, o1, s1, ref_shift(1, vals[i]));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_signed_cases();
    test_hold();
    test_param_sweep();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
